l2_localmem_ctrl: RTL and testbench

//  Sequencer and access arbiter in front of the L2 local memory (tag/state/hprot/line SRAMs + evict-way array).

---
 rtl/l2_localmem_ctrl_if.sv | 57 +++++
 rtl/l2_localmem_ctrl.sv | 140 ++++++++++++++
 tb/tb_l2_localmem_ctrl.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/l2_localmem_ctrl_if.sv
// rtl/l2_localmem_ctrl_if.sv - pipeline, local-memory and writeback signals of the L2 local-memory sequencer
interface l2_localmem_ctrl_if #(
  parameter int SETS       = 512,
  parameter int WAYS       = 8,
  parameter int STATE_BITS = 3
);
  localparam int SET_BITS = $clog2(SETS);
  localparam int WAY_BITS = $clog2(WAYS);

  logic                       pipe_rd_en;
  logic                       pipe_wr_en_line;
  logic                       pipe_wr_en_state;
  logic                       pipe_wr_en_evict_way;
  logic                       pipe_wr_en_put_reqs;
  logic [SET_BITS-1:0]        pipe_set;
  logic [WAY_BITS-1:0]        pipe_way;
  logic [STATE_BITS-1:0]      pipe_wr_data_state;
  logic                       pipe_ready;

  logic                       mem_rd_en;
  logic                       mem_wr_en_line;
  logic                       mem_wr_en_state;
  logic                       mem_wr_en_evict_way;
  logic                       mem_wr_en_put_reqs;
  logic                       mem_wr_rst;
  logic [SET_BITS-1:0]        mem_set;
  logic [WAY_BITS-1:0]        mem_way;
  logic [STATE_BITS-1:0]      mem_wr_data_state;
  logic [WAYS*STATE_BITS-1:0] mem_rd_data_state;

  logic                       evict_valid;
  logic                       evict_ready;
  logic [SET_BITS-1:0]        evict_set;
  logic [WAY_BITS-1:0]        evict_way;

  modport master (
    input  pipe_rd_en, pipe_wr_en_line, pipe_wr_en_state, pipe_wr_en_evict_way,
           pipe_wr_en_put_reqs, pipe_set, pipe_way, pipe_wr_data_state,
    output pipe_ready,
    output mem_rd_en, mem_wr_en_line, mem_wr_en_state, mem_wr_en_evict_way,
           mem_wr_en_put_reqs, mem_wr_rst, mem_set, mem_way, mem_wr_data_state,
    input  mem_rd_data_state,
    output evict_valid, evict_set, evict_way,
    input  evict_ready
  );

  modport slave (
    output pipe_rd_en, pipe_wr_en_line, pipe_wr_en_state, pipe_wr_en_evict_way,
           pipe_wr_en_put_reqs, pipe_set, pipe_way, pipe_wr_data_state,
    input  pipe_ready,
    input  mem_rd_en, mem_wr_en_line, mem_wr_en_state, mem_wr_en_evict_way,
           mem_wr_en_put_reqs, mem_wr_rst, mem_set, mem_way, mem_wr_data_state,
    output mem_rd_data_state,
    input  evict_valid, evict_set, evict_way,
    output evict_ready
  );
endinterface

// File: rtl/l2_localmem_ctrl.sv
// rtl/l2_localmem_ctrl.sv - L2 local-memory sequencer: reset sweep, pipeline forwarding, flush walk
module l2_localmem_ctrl #(
  parameter int SETS       = 512,
  parameter int WAYS       = 8,
  parameter int STATE_BITS = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_req,
  output logic             init_done,
  output logic             flush_done,
  l2_localmem_ctrl_if.master bus
);
  localparam int SET_BITS = $clog2(SETS);
  localparam int WAY_BITS = $clog2(WAYS);
  localparam logic [SET_BITS-1:0] LAST_SET = SET_BITS'(SETS - 1);

  typedef enum logic [2:0] {SWEEP, READY, FL_RD, FL_CAP, FL_SCAN, FL_EV, FL_INV} state_t;

  state_t              state, state_nx;
  logic [SET_BITS-1:0] cnt, cnt_nx;
  logic [WAYS-1:0]     mask, mask_nx, cap_mask;
  logic [WAY_BITS-1:0] way_ptr, way_ptr_nx, hit_way;
  logic                init_nx, hit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= SWEEP;
      cnt       <= '0;
      mask      <= '0;
      way_ptr   <= '0;
      init_done <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      mask      <= mask_nx;
      way_ptr   <= way_ptr_nx;
      init_done <= init_nx;
    end
  end

  always_comb begin
    for (int w = 0; w < WAYS; w++)
      cap_mask[w] = |bus.mem_rd_data_state[w*STATE_BITS +: STATE_BITS];
  end

  // Downward loop so the lowest qualifying way wins.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (mask[w] && (WAY_BITS'(w) >= way_ptr)) begin
        hit     = 1'b1;
        hit_way = WAY_BITS'(w);
      end
    end
  end

  always_comb begin
    state_nx                 = state;
    cnt_nx                   = cnt;
    mask_nx                  = mask;
    way_ptr_nx               = way_ptr;
    init_nx                  = init_done;
    flush_done               = 1'b0;
    bus.pipe_ready           = 1'b0;
    bus.mem_rd_en            = 1'b0;
    bus.mem_wr_en_line       = 1'b0;
    bus.mem_wr_en_state      = 1'b0;
    bus.mem_wr_en_evict_way  = 1'b0;
    bus.mem_wr_en_put_reqs   = 1'b0;
    bus.mem_wr_rst           = 1'b0;
    bus.mem_set              = cnt;
    bus.mem_way              = '0;
    bus.mem_wr_data_state    = '0;
    bus.evict_valid          = 1'b0;
    bus.evict_set            = cnt;
    bus.evict_way            = way_ptr;

    case (state)
      SWEEP: begin
        bus.mem_wr_rst = 1'b1;
        if (cnt == LAST_SET) begin
          state_nx = READY;
          init_nx  = 1'b1;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      READY: begin
        bus.pipe_ready          = 1'b1;
        bus.mem_rd_en           = bus.pipe_rd_en;
        bus.mem_wr_en_line      = bus.pipe_wr_en_line;
        bus.mem_wr_en_state     = bus.pipe_wr_en_state;
        bus.mem_wr_en_evict_way = bus.pipe_wr_en_evict_way;
        bus.mem_wr_en_put_reqs  = bus.pipe_wr_en_put_reqs;
        bus.mem_set             = bus.pipe_set;
        bus.mem_way             = bus.pipe_way;
        bus.mem_wr_data_state   = bus.pipe_wr_data_state;
        if (flush_req) begin
          state_nx = FL_RD;
          cnt_nx   = '0;
        end
      end
      FL_RD: begin
        bus.mem_rd_en = 1'b1;
        state_nx      = FL_CAP;
      end
      FL_CAP: begin
        mask_nx    = cap_mask;
        way_ptr_nx = '0;
        state_nx   = FL_SCAN;
      end
      FL_SCAN: begin
        if (hit) begin
          way_ptr_nx = hit_way;
          state_nx   = FL_EV;
        end else if (cnt == LAST_SET) begin
          flush_done = 1'b1;
          state_nx   = READY;
        end else begin
          cnt_nx   = cnt + 1'b1;
          state_nx = FL_RD;
        end
      end
      FL_EV: begin
        bus.evict_valid = 1'b1;
        if (bus.evict_ready) state_nx = FL_INV;
      end
      FL_INV: begin
        bus.mem_wr_en_state = 1'b1;
        bus.mem_way         = way_ptr;
        mask_nx[way_ptr]    = 1'b0;
        state_nx            = FL_SCAN;
      end
      default: state_nx = SWEEP;
    endcase
  end
endmodule

// File: tb/tb_l2_localmem_ctrl.sv
// tb/tb_l2_localmem_ctrl.sv - scoreboard bench for l2_localmem_ctrl with a behavioural local memory
module tb_l2_localmem_ctrl;
  localparam int SETS = 512;
  localparam int WAYS = 8;
  localparam int SB   = 3;

  typedef struct packed {
    logic [8:0] s;
    logic [2:0] w;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush_req = 1'b0;
  logic init_done, flush_done;

  l2_localmem_ctrl_if #(.SETS(SETS), .WAYS(WAYS), .STATE_BITS(SB)) bus ();

  l2_localmem_ctrl #(.SETS(SETS), .WAYS(WAYS), .STATE_BITS(SB)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush_req (flush_req),
    .init_done (init_done),
    .flush_done(flush_done),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int   vectors = 0;
  int   miscompares = 0;
  logic [SB-1:0] mem_arr [SETS][WAYS];
  logic [SB-1:0] ref_st  [SETS][WAYS];
  ev_t  exp_q[$];
  logic flushing   = 1'b0;
  logic ready_hold = 1'b0;
  logic ready_rand = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Local memory: synchronous writes, one-cycle read latency.
  always @(posedge clk) begin
    if (bus.mem_wr_rst)
      for (int w = 0; w < WAYS; w++) mem_arr[bus.mem_set][w] <= '0;
    if (bus.mem_wr_en_state)
      mem_arr[bus.mem_set][bus.mem_way] <= bus.mem_wr_data_state;
    if (bus.mem_rd_en)
      for (int w = 0; w < WAYS; w++) bus.mem_rd_data_state[w*SB +: SB] <= mem_arr[bus.mem_set][w];
  end

  initial begin
    bus.evict_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.evict_ready = ready_hold ? 1'b0 : (ready_rand ? 1'($urandom_range(0, 1)) : 1'b1);
    end
  end

  // Monitor: forwarding, evict scoreboard, invalidate writes, hold stability.
  initial begin
    logic prev_wait;
    ev_t  prev_ev, inv_exp, got;
    logic inv_pend;
    prev_wait = 1'b0;
    inv_pend  = 1'b0;
    prev_ev   = '0;
    inv_exp   = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_wait = 1'b0;
        inv_pend  = 1'b0;
      end else begin
        if (inv_pend)
          chk("inv_write",
              {bus.mem_wr_en_state, bus.mem_wr_rst, bus.mem_set, bus.mem_way, bus.mem_wr_data_state},
              {1'b1, 1'b0, inv_exp.s, inv_exp.w, 3'b000});
        inv_pend = 1'b0;
        if (bus.pipe_ready)
          chk("forward",
              {bus.mem_rd_en, bus.mem_wr_en_line, bus.mem_wr_en_state, bus.mem_wr_en_evict_way,
               bus.mem_wr_en_put_reqs, bus.mem_wr_rst, bus.mem_set, bus.mem_way, bus.mem_wr_data_state},
              {bus.pipe_rd_en, bus.pipe_wr_en_line, bus.pipe_wr_en_state, bus.pipe_wr_en_evict_way,
               bus.pipe_wr_en_put_reqs, 1'b0, bus.pipe_set, bus.pipe_way, bus.pipe_wr_data_state});
        if (flushing) chk("pipe_ready_in_flush", bus.pipe_ready, 0);
        if (prev_wait)
          chk("evict_hold", {bus.evict_valid, bus.evict_set, bus.evict_way}, {1'b1, prev_ev});
        if (bus.evict_valid)
          chk("evict_no_write", {bus.mem_wr_en_state, bus.mem_wr_rst, bus.mem_rd_en}, 0);
        if (bus.evict_valid && bus.evict_ready) begin
          if (exp_q.size() == 0) begin
            chk("evict_extra", {bus.evict_set, bus.evict_way}, 32'hFFFF_FFFF);
          end else begin
            got = exp_q.pop_front();
            chk("evict_addr", {bus.evict_set, bus.evict_way}, got);
            inv_pend = 1'b1;
            inv_exp  = got;
          end
        end
        prev_wait = bus.evict_valid && !bus.evict_ready;
        prev_ev   = {bus.evict_set, bus.evict_way};
        if (flush_done) begin
          chk("flush_done_expected", flushing, 1);
          chk("flush_leftover", exp_q.size(), 0);
        end
      end
    end
  end

  task automatic pipe_idle();
    bus.pipe_rd_en           = 1'b0;
    bus.pipe_wr_en_line      = 1'b0;
    bus.pipe_wr_en_state     = 1'b0;
    bus.pipe_wr_en_evict_way = 1'b0;
    bus.pipe_wr_en_put_reqs  = 1'b0;
    bus.pipe_set             = '0;
    bus.pipe_way             = '0;
    bus.pipe_wr_data_state   = '0;
  endtask

  task automatic pipe_op(input logic rd, input logic wl, input logic ws, input logic we, input logic wp,
                         input logic [8:0] set, input logic [2:0] way, input logic [2:0] data);
    @(posedge clk);
    #1;
    bus.pipe_rd_en           = rd;
    bus.pipe_wr_en_line      = wl;
    bus.pipe_wr_en_state     = ws;
    bus.pipe_wr_en_evict_way = we;
    bus.pipe_wr_en_put_reqs  = wp;
    bus.pipe_set             = set;
    bus.pipe_way             = way;
    bus.pipe_wr_data_state   = data;
    if (bus.pipe_ready && ws) ref_st[set][way] = data;
  endtask

  task automatic rand_traffic(input int n);
    for (int i = 0; i < n; i++)
      pipe_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 9'($urandom_range(0, SETS - 1)),
              3'($urandom_range(0, WAYS - 1)), 3'($urandom_range(0, 7)));
    @(posedge clk);
    #1;
    pipe_idle();
  endtask

  task automatic clear_ref();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) ref_st[s][w] = '0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    flush_req = 1'b0;
    flushing = 1'b0;
    ready_hold = 1'b0;
    pipe_idle();
    exp_q.delete();
    clear_ref();
    repeat (3) @(negedge clk);
    chk("rst_status", {bus.pipe_ready, init_done, flush_done, bus.evict_valid}, 0);
    chk("rst_mem_ctl", {bus.mem_rd_en, bus.mem_wr_en_line, bus.mem_wr_en_state, bus.mem_wr_en_evict_way,
                        bus.mem_wr_en_put_reqs, bus.mem_wr_rst, bus.mem_set}, {6'b000001, 9'd0});
    #1;
    rst = 1'b1;
    for (int i = 0; i < SETS; i++) begin
      chk("sweep", {bus.mem_wr_rst, bus.mem_set, bus.mem_wr_data_state, init_done, bus.pipe_ready},
          {1'b1, 9'(i), 3'b000, 1'b0, 1'b0});
      @(negedge clk);
    end
    chk("init_done", {init_done, bus.pipe_ready, bus.mem_wr_rst}, 3'b110);
  endtask

  task automatic build_expect();
    exp_q.delete();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++)
        if (ref_st[s][w] != '0) begin
          exp_q.push_back({9'(s), 3'(w)});
          ref_st[s][w] = '0;
        end
  endtask

  task automatic start_flush();
    @(posedge clk);
    #1;
    chk("flush_start_ready", bus.pipe_ready, 1);
    flush_req = 1'b1;
    pipe_idle();
    bus.pipe_rd_en = 1'b1;
    bus.pipe_set   = 9'($urandom_range(0, SETS - 1));
    @(posedge clk);
    #1;
    flush_req = 1'b0;
    pipe_idle();
    flushing = 1'b1;
  endtask

  task automatic run_flush(input bit hold);
    int held = 0;
    bit done = 0;
    int nz = 0;
    build_expect();
    ready_hold = hold;
    start_flush();
    for (int c = 0; c < 20000 && !done; c++) begin
      @(negedge clk);
      if (flush_done) done = 1;
      else if (hold && bus.evict_valid) begin
        held++;
        if (held >= 10) ready_hold = 1'b0;
      end
    end
    #1;
    flushing = 1'b0;
    ready_hold = 1'b0;
    chk("flush_complete", done, 1);
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++)
        if (mem_arr[s][w] != '0) nz++;
    chk("flush_mem_clean", nz, 0);
    @(negedge clk);
    chk("ready_after_flush", bus.pipe_ready, 1);
  endtask

  task automatic run_abort();
    bit seen = 0;
    build_expect();
    ready_hold = 1'b1;
    start_flush();
    for (int c = 0; c < 20000 && !seen; c++) begin
      @(negedge clk);
      if (bus.evict_valid) seen = 1;
    end
    chk("abort_evict_seen", seen, 1);
    @(posedge clk);
    #2;
    rst = 1'b0;
    flushing = 1'b0;
    #1;
    chk("abort_evict_dropped", bus.evict_valid, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    pipe_idle();
    clear_ref();
    do_reset();

    pipe_op(0, 0, 1, 0, 0, 9'd0, 3'd1, 3'($urandom_range(1, 7)));
    pipe_op(0, 0, 1, 0, 0, 9'd0, 3'd6, 3'($urandom_range(1, 7)));
    pipe_op(1, 0, 0, 0, 0, 9'd0, 3'd0, 3'd0);
    @(posedge clk);
    #1;
    pipe_idle();
    run_flush(0);

    pipe_op(0, 0, 1, 0, 0, 9'd5, 3'd3, 3'b011);
    @(negedge clk);
    chk("pipe_wr_state_fwd", {bus.mem_wr_en_state, bus.mem_set, bus.mem_way, bus.mem_wr_data_state},
        {1'b1, 9'd5, 3'd3, 3'b011});
    rand_traffic(150);
    ready_rand = 1'b1;
    run_flush(1);

    rand_traffic(100);
    pipe_op(0, 0, 1, 0, 0, 9'd7, 3'd2, 3'b101);
    @(posedge clk);
    #1;
    pipe_idle();
    run_abort();
    do_reset();

    rand_traffic(80);
    run_flush(0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
